spi_byte_shifter: RTL and testbench
===================================

// Module: spi_byte_shifter
// PURPOSE
//   Byte-level SPI master shift engine for the SPI NOR flash path. Sits downstream
//   of the APB command sequencer and is the consumer of the divided serial clock.
//   SCK is generated internally as clk_in/DIV, so the block stays on one clock.
//   Mode 0 (CPOL=0, CPHA=0), MSB first. Drives the flash pins directly.
// PARAMETERS
//   DIV       4   clk_in cycles per SCK period; even, >=2 (elaboration $error otherwise)
//   CS_GAP    2   SCK half-periods that spi_cs_n stays high after a frame ends (>=1)
// PORTS
//   clk_in     in   1  system clock
//   rst        in   1  asynchronous reset, active low
//   tx_valid   in   1  upstream byte available
//   tx_ready   out  1  engine accepts byte this cycle
//   tx_data    in   8  byte to transmit
//   tx_last    in   1  byte ends the frame; sampled with tx_data
//   rx_valid   out  1  one-cycle pulse: rx_data holds the byte just received
//   rx_data    out  8  received byte
//   busy       out  1  high whenever spi_cs_n is low or a CS gap is running
//   spi_sck    out  1  serial clock
//   spi_cs_n   out  1  chip select, active low
//   spi_mosi   out  1  serial data out
//   spi_miso   in   1  serial data in
// BEHAVIOUR
//   Reset (async, rst=0): state IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0,
//     tx_ready=1, rx_valid=0, rx_data=0, busy=0, all counters 0. Mid-frame reset
//     aborts at once: cs_n rises, no rx_valid.
//   Half-period counter counts 0..DIV/2-1; each wrap is one SCK "tick".
//   States: IDLE -> SHIFT -> (HOLD | GAP); HOLD -> SHIFT; GAP -> IDLE.
//   IDLE: cs_n=1, tx_ready=1. Accept on tx_valid&tx_ready (cycle 0): latch
//     tx_data/tx_last. cs_n=0 and mosi=bit7 from cycle 1. Go to SHIFT.
//   SHIFT: ticks alternate rise/fall, starting with a rise. First rise at cycle
//     1+DIV/2. On each rise edge, spi_miso is shifted into rx shift reg (LSB in).
//     On falls 1..7, mosi presents the next bit. On the 8th fall (cycle 1+8*DIV):
//     sck=0, rx_valid=1 for that cycle, rx_data updated. Then HOLD if !tx_last,
//     else GAP. tx_ready=0 throughout SHIFT.
//   HOLD: cs_n stays 0, sck=0, tx_ready=1. Accept loads mosi=bit7 on the next
//     cycle and reenters SHIFT with identical timing relative to accept.
//     No timeout: HOLD waits indefinitely.
//   GAP: cs_n=1, tx_ready=0 for CS_GAP*DIV/2 cycles, then IDLE. tx_valid ignored.
//   busy = (state != IDLE). rx_valid never coincides with tx_ready=1 in the same
//     state entry. An accept in the cycle after rx_valid is legal.
//   mosi holds last driven bit when not shifting; value is don't-care with cs_n=1.
// CONFIGURATION
//   SPI_LSB_FIRST_EN defined: tx bits sent bit0 first; rx bits stored so the
//     first received bit lands in rx_data[0]. Timing unchanged.
//   Undefined (default): MSB first on both directions, as above.
// TESTING
//   DIV=4; single byte 0xA5 tx_last=1, miso loops mosi -> cs_n low at cycle 1;
//     sck rises at 3,7,..,31; rx_valid at cycle 33 with rx_data=0xA5; cs_n high at 34
//   Back-to-back 0x9F (last=0), 0x00 (last=1) accepted in HOLD -> cs_n low for
//     both bytes, two rx_valid pulses, exactly 16 SCK rises, gap of CS_GAP*2 cycles
//   miso tied 1 with tx 0x03 -> rx_data=0xFF; mosi pattern 0,0,0,0,0,0,1,1 on rises
//   Assert rst low at cycle 15 of a byte -> cs_n=1, sck=0 same cycle, no rx_valid,
//     tx_ready=1 after release
//   tx_valid held high during GAP -> not accepted until IDLE; tx_ready=0 in GAP
//   SPI_LSB_FIRST_EN build, tx 0x01 -> first mosi bit 1, loopback rx_data=0x01

Source files
------------

// File: rtl/spi_byte_shifter_if.sv
// Bus bundle for spi_byte_shifter: upstream byte handshake, received-byte
// strobe, status and the four flash pins.
// slave  : the shift engine itself.
// master : the environment side (command sequencer plus flash device).
interface spi_byte_shifter_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;

  modport slave (
    input  tx_valid, tx_data, tx_last, spi_miso,
    output tx_ready, rx_valid, rx_data, busy, spi_sck, spi_cs_n, spi_mosi
  );

  modport master (
    output tx_valid, tx_data, tx_last, spi_miso,
    input  tx_ready, rx_valid, rx_data, busy, spi_sck, spi_cs_n, spi_mosi
  );
endinterface

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: byte-level SPI master shift engine (mode 0) for the SPI NOR
// flash path. SCK is derived from clk_in as clk_in/DIV so the block runs on a
// single clock; every pin and status output is a flop.
// Build option: define SPI_LSB_FIRST_EN to transmit bit0 first and to store the
// first received bit in rx_data[0]. Default (undefined) is MSB first both ways.
module spi_byte_shifter #(
  parameter int DIV    = 4,
  parameter int CS_GAP = 2
) (
  input logic               clk_in,
  input logic               rst,
  spi_byte_shifter_if.slave bus
);

  localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP * DIV / 2 - 1);

  generate
    if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
      $error("spi_byte_shifter: DIV must be even and >= 2");
    end
    if (CS_GAP < 1) begin : g_bad_gap
      $error("spi_byte_shifter: CS_GAP must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Bit-order helpers: the only place the shift direction is decided.
  function automatic logic first_bit(input logic [7:0] b);
`ifdef SPI_LSB_FIRST_EN
    return b[0];
`else
    return b[7];
`endif
  endfunction

  function automatic logic next_bit(input logic [7:0] sh);
`ifdef SPI_LSB_FIRST_EN
    return sh[1];
`else
    return sh[6];
`endif
  endfunction

  function automatic logic [7:0] tx_shift(input logic [7:0] sh);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, sh[7:1]};
`else
    return {sh[6:0], 1'b0};
`endif
  endfunction

  function automatic logic [7:0] rx_shift(input logic [7:0] sh, input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, sh[7:1]};
`else
    return {sh[6:0], b};
`endif
  endfunction

  state_t      state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [3:0]  tick_q, tick_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        last_q, last_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;
  logic        accept_s;

  assign accept_s = bus.tx_valid & tx_ready_q;

  // Next-state and datapath: half-period ticks drive SCK, MOSI and MISO sampling.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    tick_d     = tick_q;
    gap_d      = gap_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        sck_d  = 1'b0;
        hcnt_d = 16'd0;
        tick_d = 4'd0;
        gap_d  = 16'd0;
        if (accept_s) begin
          state_d = ST_SHIFT;
          tx_sh_d = bus.tx_data;
          last_d  = bus.tx_last;
          mosi_d  = first_bit(bus.tx_data);
        end else begin
          state_d = state_q;
        end
      end
      ST_SHIFT: begin
        if (rx_valid_q) begin
          // Byte finished last cycle; cs_n stayed low for the rx_valid cycle.
          hcnt_d  = 16'd0;
          tick_d  = 4'd0;
          gap_d   = 16'd0;
          state_d = last_q ? ST_GAP : ST_HOLD;
        end else if (hcnt_q == HALF_LAST) begin
          hcnt_d = 16'd0;
          tick_d = tick_q + 4'd1;
          if (!tick_q[0]) begin
            // Even tick: rising edge, sample the flash output.
            sck_d   = 1'b1;
            rx_sh_d = rx_shift(rx_sh_q, bus.spi_miso);
          end else begin
            sck_d = 1'b0;
            if (tick_q == 4'd15) begin
              rx_valid_d = 1'b1;
              rx_data_d  = rx_sh_q;
            end else begin
              tx_sh_d = tx_shift(tx_sh_q);
              mosi_d  = next_bit(tx_sh_q);
            end
          end
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = 16'd0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status pins are decoded from the next state so they are flops too.
    cs_n_d     = (state_d == ST_IDLE) || (state_d == ST_GAP);
    tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hcnt_q     <= 16'd0;
      tick_q     <= 4'd0;
      gap_q      <= 16'd0;
      tx_sh_q    <= 8'd0;
      rx_sh_q    <= 8'd0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      tick_q     <= tick_d;
      gap_q      <= gap_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = busy_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Testbench for spi_byte_shifter (DIV=4, CS_GAP=2). A flash model on MISO
// (loopback / tied high / tied low) and a queue of expected bytes checked on
// every rx_valid, a vector table, and hand-written multi-cycle sequences.
module tb_spi_byte_shifter;
  localparam int DIV     = 4;
  localparam int CS_GAP  = 2;
  localparam int GAP_CYC = CS_GAP * DIV / 2;
  localparam logic [1:0] M_LOOP = 2'd0;
  localparam logic [1:0] M_ONE  = 2'd1;
  localparam logic [1:0] M_ZERO = 2'd2;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [1:0] miso_mode;

  spi_byte_shifter_if bus_if();

  spi_byte_shifter #(.DIV(DIV), .CS_GAP(CS_GAP)) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus_if)
  );

  always #5 clk_in = ~clk_in;

  // Flash model on MISO.
  always_comb begin
    bus_if.spi_miso = 1'b0;
    case (miso_mode)
      M_LOOP:  bus_if.spi_miso = bus_if.spi_mosi;
      M_ONE:   bus_if.spi_miso = 1'b1;
      default: bus_if.spi_miso = 1'b0;
    endcase
  end

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mosi;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] mode;
    logic [7:0] exp_rx;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[7];

  int total = 0;
  int bad   = 0;
  int rise_cnt = 0, rx_cnt = 0, gap_cyc_cnt = 0, cs_rise_cnt = 0;
  logic       prev_sck = 1'b0;
  logic       prev_cs_n = 1'b1;
  logic [7:0] mosi_cap = 8'd0;
  logic [40:0] cs_v, sck_v, rxv_v, rdy_v, busy_v;

  // Order in which the byte should appear on MOSI, first bit in position 7.
  function automatic logic [7:0] exp_mosi(input logic [7:0] d);
    logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
    for (int k = 0; k < 8; k++) r[k] = d[7-k];
`else
    r = d;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus_if.tx_ready && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    if (!bus_if.tx_ready) begin
      total++;
      bad++;
      $display("FAIL %s: tx_ready still 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: %0d bytes never received, required 0", name, sb.size());
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] m,
                      input logic [7:0] exp_rx);
    miso_mode        = m;
    bus_if.tx_data   = d;
    bus_if.tx_last   = l;
    bus_if.tx_valid  = 1'b1;
    sb.push_back('{rx: exp_rx, mosi: exp_mosi(d)});
  endtask

  // Monitor: SCK rises, CS gap cycles, and scoreboard check on each rx_valid.
  always @(negedge clk_in) begin
    if (bus_if.spi_sck && !prev_sck) begin
      rise_cnt++;
      mosi_cap = {mosi_cap[6:0], bus_if.spi_mosi};
    end
    if (bus_if.spi_cs_n && !prev_cs_n) cs_rise_cnt++;
    if (bus_if.spi_cs_n && bus_if.busy) gap_cyc_cnt++;
    if (bus_if.rx_valid) begin
      rx_cnt++;
      check("rx_ready_overlap", {31'd0, bus_if.tx_ready}, 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data=%02h, required none", bus_if.rx_data);
      end else begin
        e = sb.pop_front();
        check("rx_data", {24'd0, bus_if.rx_data}, {24'd0, e.rx});
        check("mosi_bits", {24'd0, mosi_cap}, {24'd0, e.mosi});
      end
    end
    prev_sck  = bus_if.spi_sck;
    prev_cs_n = bus_if.spi_cs_n;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, c0, x0, g0, first_rise, last_rise, rises, gap_seen;
    logic prev_last;

    vecs[0] = '{8'h03, 1'b1, M_ONE,  8'hFF};
    vecs[1] = '{8'h3C, 1'b1, M_ZERO, 8'h00};
    vecs[2] = '{8'h5A, 1'b0, M_LOOP, 8'h5A};
    vecs[3] = '{8'hC3, 1'b1, M_LOOP, 8'hC3};
    vecs[4] = '{8'hE7, 1'b0, M_ONE,  8'hFF};
    vecs[5] = '{8'h18, 1'b1, M_LOOP, 8'h18};
    vecs[6] = '{8'h01, 1'b1, M_LOOP, 8'h01};

    rst = 1'b0;
    miso_mode = M_LOOP;
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = 8'd0;
    bus_if.tx_last  = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst_cs_n",     {31'd0, bus_if.spi_cs_n}, 32'd1);
    check("rst_sck",      {31'd0, bus_if.spi_sck},  32'd0);
    check("rst_mosi",     {31'd0, bus_if.spi_mosi}, 32'd0);
    check("rst_tx_ready", {31'd0, bus_if.tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, bus_if.rx_valid}, 32'd0);
    check("rst_rx_data",  {24'd0, bus_if.rx_data},  32'd0);
    check("rst_busy",     {31'd0, bus_if.busy},     32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk_in);

    // Single byte 0xA5, cycle-accurate timing; this negedge is cycle 0.
    send(8'hA5, 1'b1, M_LOOP, 8'hA5);
    cs_v[0] = 1'b1; sck_v[0] = 1'b0; rxv_v[0] = 1'b0; rdy_v[0] = 1'b1; busy_v[0] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_in);
      if (c == 1) bus_if.tx_valid = 1'b0;
      cs_v[c]   = bus_if.spi_cs_n;
      sck_v[c]  = bus_if.spi_sck;
      rxv_v[c]  = bus_if.rx_valid;
      rdy_v[c]  = bus_if.tx_ready;
      busy_v[c] = bus_if.busy;
    end
    rises = 0; first_rise = -1; last_rise = -1;
    for (int c = 1; c <= 40; c++) begin
      if (sck_v[c] && !sck_v[c-1]) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        last_rise = c;
      end
    end
    check("t_cs_low_c1",   {31'd0, cs_v[1]},  32'd0);
    check("t_ready_c5",    {31'd0, rdy_v[5]}, 32'd0);
    check("t_first_rise",  first_rise, 32'd3);
    check("t_last_rise",   last_rise,  32'd31);
    check("t_rises",       rises,      32'd8);
    check("t_rxv_c32",     {31'd0, rxv_v[32]}, 32'd0);
    check("t_rxv_c33",     {31'd0, rxv_v[33]}, 32'd1);
    check("t_cs_c33",      {31'd0, cs_v[33]},  32'd0);
    check("t_cs_c34",      {31'd0, cs_v[34]},  32'd1);
    check("t_ready_c34",   {31'd0, rdy_v[34]}, 32'd0);
    check("t_busy_c37",    {31'd0, busy_v[37]}, 32'd1);
    check("t_busy_c38",    {31'd0, busy_v[38]}, 32'd0);
    check("t_ready_c38",   {31'd0, rdy_v[38]}, 32'd1);
    wait_drain("t_drain");

    // Back-to-back frame: 0x9F (not last) then 0x00 (last) accepted in HOLD.
    wait_ready("b2b_ready0");
    r0 = rise_cnt; c0 = cs_rise_cnt; x0 = rx_cnt; g0 = gap_cyc_cnt;
    send(8'h9F, 1'b0, M_LOOP, 8'h9F);
    @(negedge clk_in);
    bus_if.tx_valid = 1'b0;
    wait_ready("b2b_hold");
    check("b2b_hold_cs", {31'd0, bus_if.spi_cs_n}, 32'd0);
    send(8'h00, 1'b1, M_LOOP, 8'h00);
    @(negedge clk_in);
    bus_if.tx_valid = 1'b0;
    check("b2b_cs_second", {31'd0, bus_if.spi_cs_n}, 32'd0);
    wait_drain("b2b_drain");
    wait_ready("b2b_idle");
    check("b2b_rises",     rise_cnt - r0,    32'd16);
    check("b2b_cs_rises",  cs_rise_cnt - c0, 32'd1);
    check("b2b_rx_pulses", rx_cnt - x0,      32'd2);
    check("b2b_gap",       gap_cyc_cnt - g0, GAP_CYC);

    // Vector table.
    prev_last = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_ready("vec_ready");
      check("vec_cs_at_ready", {31'd0, bus_if.spi_cs_n}, {31'd0, prev_last});
      send(vecs[i].data, vecs[i].last, vecs[i].mode, vecs[i].exp_rx);
      @(negedge clk_in);
      bus_if.tx_valid = 1'b0;
      wait_drain("vec_drain");
      prev_last = vecs[i].last;
    end
    wait_ready("vec_end");

    // tx_valid held high across the CS gap: next byte only taken in IDLE.
    send(8'h66, 1'b1, M_LOOP, 8'h66);
    @(negedge clk_in);
    bus_if.tx_data = 8'h81;
    r0 = 0;
    while (!(bus_if.spi_cs_n && bus_if.busy) && r0 < 100) begin
      @(negedge clk_in);
      r0++;
    end
    check("gh_gap_seen", {31'd0, bus_if.spi_cs_n && bus_if.busy}, 32'd1);
    gap_seen = 0;
    while (!bus_if.tx_ready && gap_seen < 50) begin
      gap_seen++;
      @(negedge clk_in);
    end
    check("gh_gap_len", gap_seen, GAP_CYC);
    check("gh_cs_in_idle", {31'd0, bus_if.spi_cs_n}, 32'd1);
    sb.push_back('{rx: 8'h81, mosi: exp_mosi(8'h81)});
    @(negedge clk_in);
    check("gh_accept_idle", {31'd0, bus_if.spi_cs_n}, 32'd0);
    bus_if.tx_valid = 1'b0;
    wait_drain("gh_drain");
    wait_ready("gh_end");

    // Reset asserted at cycle 15 of a byte.
    x0 = rx_cnt;
    miso_mode = M_LOOP;
    bus_if.tx_data  = 8'h77;
    bus_if.tx_last  = 1'b1;
    bus_if.tx_valid = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_in);
      if (c == 1) bus_if.tx_valid = 1'b0;
    end
    check("mr_sck_before", {31'd0, bus_if.spi_sck}, 32'd1);
    rst = 1'b0;
    #1;
    check("mr_cs_n",     {31'd0, bus_if.spi_cs_n}, 32'd1);
    check("mr_sck",      {31'd0, bus_if.spi_sck},  32'd0);
    check("mr_busy",     {31'd0, bus_if.busy},     32'd0);
    check("mr_rx_valid", {31'd0, bus_if.rx_valid}, 32'd0);
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    repeat (40) @(negedge clk_in);
    check("mr_no_rx",       rx_cnt - x0, 32'd0);
    check("mr_ready_after", {31'd0, bus_if.tx_ready}, 32'd1);
    check("mr_cs_after",    {31'd0, bus_if.spi_cs_n}, 32'd1);
    check("sb_empty",       sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
